// File: rtl/ibex_wb_buffer.sv
// In-order writeback buffer between EX and the register file, with decode hazard/forward lookup (forwarding: IBEX_WB_FWD_EN).
// Latency: an entry pushed at edge N can retire in cycle N+1; a load retires the cycle after its data arrives.
// Backpressure: ex_ready_o = !full from registered count only; a retire in a full cycle does not free the slot early.
module ibex_wb_buffer #(
    parameter int unsigned Depth = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ex_valid_i,
    output logic        ex_ready_o,
    input  logic        ex_rf_we_i,
    input  logic [4:0]  ex_rf_waddr_i,
    input  logic [31:0] ex_result_i,
    input  logic        ex_load_i,
    input  logic        lsu_rdata_valid_i,
    input  logic [31:0] lsu_rdata_i,
    input  logic        lsu_err_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic        instr_done_o,
    output logic        load_err_o,
    input  logic [4:0]  rf_raddr_a_i,
    input  logic [4:0]  rf_raddr_b_i,
    output logic        hazard_a_o,
    output logic        hazard_b_o,
    output logic        fwd_valid_a_o,
    output logic        fwd_valid_b_o,
    output logic [31:0] fwd_data_a_o,
    output logic [31:0] fwd_data_b_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] data;
        logic        pending;
        logic        err;
    } wb_entry_t;

    wb_entry_t        entries_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;

    wb_entry_t        head;
    logic             push;
    logic             pop;
    logic             merge_hit;
    logic [PtrW-1:0]  merge_idx;

    assign head       = entries_q[rd_ptr_q];
    assign pop        = head.valid && !head.pending;
    assign ex_ready_o = (count_q != FullCnt);
    assign push       = ex_valid_i && ex_ready_o;

    assign rf_we_o      = pop && head.we && !head.err;
    assign rf_waddr_o   = pop ? head.waddr : 5'd0;
    assign rf_wdata_o   = pop ? head.data : 32'd0;
    assign instr_done_o = pop;
    assign load_err_o   = pop && head.err;

    // Walk youngest-to-oldest so the last hit is the oldest pending load.
    always_comb begin
        merge_hit = 1'b0;
        merge_idx = '0;
        for (int i = Depth - 1; i >= 0; i--) begin
            if (entries_q[rd_ptr_q + PtrW'(i)].valid && entries_q[rd_ptr_q + PtrW'(i)].pending) begin
                merge_hit = 1'b1;
                merge_idx = rd_ptr_q + PtrW'(i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < Depth; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            if (lsu_rdata_valid_i && merge_hit) begin
                entries_q[merge_idx].pending <= 1'b0;
                entries_q[merge_idx].err     <= lsu_err_i;
                entries_q[merge_idx].data    <= lsu_err_i ? 32'd0 : lsu_rdata_i;
            end
            if (pop) begin
                entries_q[rd_ptr_q].valid <= 1'b0;
                rd_ptr_q                  <= rd_ptr_q + PtrW'(1);
            end
            // The push slot is never the pop slot or a merge target: it is invalid unless full.
            if (push) begin
                entries_q[wr_ptr_q].valid   <= 1'b1;
                entries_q[wr_ptr_q].we      <= ex_rf_we_i && (ex_rf_waddr_i != 5'd0);
                entries_q[wr_ptr_q].waddr   <= ex_rf_waddr_i;
                entries_q[wr_ptr_q].data    <= ex_load_i ? 32'd0 : ex_result_i;
                entries_q[wr_ptr_q].pending <= ex_load_i;
                entries_q[wr_ptr_q].err     <= 1'b0;
                wr_ptr_q                    <= wr_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    logic [1:0][4:0]  raddr;
    logic [1:0]       hazard;
    logic [1:0]       fwd_vld;
    logic [1:0][31:0] fwd_dat;

    assign raddr[0] = rf_raddr_a_i;
    assign raddr[1] = rf_raddr_b_i;

    // Valid entries are contiguous from rd_ptr, so the last match in this walk is the youngest.
    for (genvar p = 0; p < 2; p++) begin : g_rport
`ifdef IBEX_WB_FWD_EN
        logic      hit;
        wb_entry_t match;
        always_comb begin
            hit   = 1'b0;
            match = '0;
            for (int i = 0; i < Depth; i++) begin
                if (entries_q[rd_ptr_q + PtrW'(i)].valid && entries_q[rd_ptr_q + PtrW'(i)].we &&
                    entries_q[rd_ptr_q + PtrW'(i)].waddr == raddr[p]) begin
                    hit   = 1'b1;
                    match = entries_q[rd_ptr_q + PtrW'(i)];
                end
            end
            if (raddr[p] == 5'd0) begin
                hit = 1'b0;
            end
        end
        assign hazard[p]  = hit && (match.pending || match.err);
        assign fwd_vld[p] = hit && !match.pending && !match.err;
        assign fwd_dat[p] = fwd_vld[p] ? match.data : 32'd0;
`else
        logic hit;
        always_comb begin
            hit = 1'b0;
            for (int i = 0; i < Depth; i++) begin
                if (entries_q[rd_ptr_q + PtrW'(i)].valid && entries_q[rd_ptr_q + PtrW'(i)].we &&
                    entries_q[rd_ptr_q + PtrW'(i)].waddr == raddr[p]) begin
                    hit = 1'b1;
                end
            end
            if (raddr[p] == 5'd0) begin
                hit = 1'b0;
            end
        end
        assign hazard[p]  = hit;
        assign fwd_vld[p] = 1'b0;
        assign fwd_dat[p] = 32'd0;
`endif
    end

    assign hazard_a_o    = hazard[0];
    assign hazard_b_o    = hazard[1];
    assign fwd_valid_a_o = fwd_vld[0];
    assign fwd_valid_b_o = fwd_vld[1];
    assign fwd_data_a_o  = fwd_dat[0];
    assign fwd_data_b_o  = fwd_dat[1];

endmodule
